// File: rtl/mult_pkg.sv
// Shared types and defaults for the approximate-multiplier datapath.
// Holds the partial-product and product widths and the accumulator FSM encoding.
package mult_pkg;

  localparam int unsigned DEF_WIDTH      = 16;
  localparam int unsigned DEF_ROWS       = 16;
  localparam int unsigned DEF_TRUNC_BITS = 8;
  localparam int unsigned PROD_W         = DEF_WIDTH + DEF_ROWS;

  typedef logic [DEF_WIDTH-1:0] pp_t;
  typedef logic [PROD_W-1:0]    prod_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

endpackage

// File: rtl/pp_shift_mask.sv
// Aligns one partial-product row to its weight 2^cnt in the product word.
// Compile option APPROX_TRUNC_EN: zero the low TRUNC_BITS of every aligned row
// (lower-part truncation), so the low product bits are never accumulated.
module pp_shift_mask
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned ROWS       = DEF_ROWS,
  parameter int unsigned TRUNC_BITS = DEF_TRUNC_BITS
) (
  input  logic [WIDTH-1:0]         i_pp,
  input  logic [$clog2(ROWS)-1:0]  i_cnt,
  output logic [WIDTH+ROWS-1:0]    o_row
);

  localparam int unsigned PW = WIDTH + ROWS;

  // Truncating every product bit would leave nothing to accumulate.
  if (TRUNC_BITS > PW - 1) begin : g_trunc_range
    $error("pp_shift_mask: TRUNC_BITS must lie in 0..WIDTH+ROWS-1");
  end

  logic [PW-1:0] w_shifted;

  assign w_shifted = {{ROWS{1'b0}}, i_pp} << i_cnt;

`ifdef APPROX_TRUNC_EN
  // Constant mask: the zeroed low bits let synthesis drop that adder slice.
  localparam logic [PW-1:0] TRUNC_MASK = ~((PW'(1) << TRUNC_BITS) - PW'(1));

  assign o_row = w_shifted & TRUNC_MASK;
`else
  assign o_row = w_shifted;
`endif

endmodule

// File: rtl/pp_accumulator.sv
// Partial-product accumulator: takes ROWS rows in order, shift-adds row k at
// weight 2^k into a WIDTH+ROWS-bit sum and offers the product on a
// valid/ready handshake. Compile option APPROX_TRUNC_EN enables lower-part
// truncation inside pp_shift_mask.
module pp_accumulator
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned ROWS       = DEF_ROWS,
  parameter int unsigned TRUNC_BITS = DEF_TRUNC_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          pp_in,
  input  logic                      pp_valid,
  output logic                      pp_ready,
  output logic [$clog2(ROWS)-1:0]   row_idx,
  output logic [WIDTH+ROWS-1:0]     prod,
  output logic                      prod_valid,
  input  logic                      prod_ready
);

  localparam int unsigned        PW       = WIDTH + ROWS;
  localparam int unsigned        CNT_W    = $clog2(ROWS);
  localparam logic [CNT_W-1:0]   LAST_ROW = CNT_W'(ROWS - 1);

  acc_state_t       r_state;
  acc_state_t       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    w_row;
  logic             w_xfer;
  logic             w_last;

  assign w_xfer = pp_valid && pp_ready;
  assign w_last = (r_cnt == LAST_ROW);

  pp_shift_mask #(
    .WIDTH      (WIDTH),
    .ROWS       (ROWS),
    .TRUNC_BITS (TRUNC_BITS)
  ) u_shift_mask (
    .i_pp  (pp_in),
    .i_cnt (r_cnt),
    .o_row (w_row)
  );

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: row 0 leaves IDLE, the last row enters DONE, prod_ready releases DONE.
  always_comb begin
    // NOTE: default assignment first, so no path leaves w_next unassigned (no latch).
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_xfer) w_next = w_last ? DONE : ACCUM;
      ACCUM:   if (w_xfer && w_last) w_next = DONE;
      DONE:    if (prod_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output decode: rows are taken outside DONE, the product is offered only in DONE; both quiet in reset.
  always_comb begin
    pp_ready   = 1'b0;
    prod_valid = 1'b0;
    case (r_state)
      IDLE, ACCUM: pp_ready   = !rst;
      DONE:        prod_valid = !rst;
      default:     ;
    endcase
  end

  // Accumulator and row counter: add on each transfer, hold in DONE, clear on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == DONE) begin
      if (prod_ready) begin
        r_acc <= '0;
        r_cnt <= '0;
      end
    end else if (w_xfer) begin
      // Counter parks on the last row; only the DONE->IDLE handshake rewinds it.
      r_acc <= r_acc + w_row;
      if (!w_last) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign row_idx = r_cnt;
  assign prod    = r_acc;

endmodule

// File: tb/tb_pp_accumulator.sv
// Self-checking bench for pp_accumulator. Build with +define+APPROX_TRUNC_EN to
// check the truncating variant; expected values follow the same macro.
module tb_pp_accumulator;
  import mult_pkg::*;

  localparam int W  = 16;
  localparam int R  = 16;
  localparam int TB = 8;

`ifdef APPROX_TRUNC_EN
  localparam int          EFF_TRUNC = TB;
  localparam longint unsigned EXP_FFFF = 64'hFFFD_F900;
`else
  localparam int          EFF_TRUNC = 0;
  localparam longint unsigned EXP_FFFF = 64'hFFFE_0001;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  pp_in;
  logic          pp_valid;
  logic          pp_ready;
  logic [3:0]    row_idx;
  logic [W+R-1:0] prod;
  logic          prod_valid;
  logic          prod_ready;

  always #5 clk = ~clk;

  pp_accumulator #(
    .WIDTH      (W),
    .ROWS       (R),
    .TRUNC_BITS (TB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pp_in      (pp_in),
    .pp_valid   (pp_valid),
    .pp_ready   (pp_ready),
    .row_idx    (row_idx),
    .prod       (prod),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] rows [R];

  typedef struct {
    logic [15:0]     a;
    logic [15:0]     b;
    longint unsigned exp_exact;
    longint unsigned exp_trunc;
    int              hold;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: product = sum over k of (row_k * 2^k), with the low EFF_TRUNC
  // bits of each weighted term dropped.
  function automatic longint unsigned model();
    longint unsigned s    = 0;
    longint unsigned mask = ~((64'd1 << EFF_TRUNC) - 64'd1);
    for (int k = 0; k < R; k++) s += ((64'(rows[k]) * (64'd1 << k)) & mask);
    return s;
  endfunction

  // gap_mode: 0 back-to-back, 1 idle cycle between rows, 2 random 0..2 idle cycles.
  task automatic send_rows(input int nrows, input int gap_mode);
    for (int k = 0; k < nrows; k++) begin
      int gaps;
      int waitc;
      gaps = (gap_mode == 1 && k > 0) ? 1 : (gap_mode == 2 ? int'($urandom_range(0, 2)) : 0);
      for (int g = 0; g < gaps; g++) begin
        pp_valid = 1'b0;
        pp_in    = W'($urandom);
        tick();
        check("row_idx_in_gap", row_idx, k);
      end
      pp_valid = 1'b0;
      waitc    = 0;
      while (!pp_ready && waitc < 50) begin
        tick();
        waitc++;
      end
      check("pp_ready_before_row", pp_ready, 1);
      check("row_idx_before_row", row_idx, k);
      if (k == R - 1) check("prod_valid_before_last", prod_valid, 0);
      pp_valid = 1'b1;
      pp_in    = rows[k];
      tick();
    end
    pp_valid = 1'b0;
    pp_in    = W'($urandom);
  endtask

  // Called right after the last transfer: product must already be valid.
  task automatic finish_product(input longint unsigned exp, input int hold, input logic bp_valid);
    check("prod_valid_rise", prod_valid, 1);
    check("prod_value", prod, exp);
    prod_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      pp_valid = bp_valid;
      pp_in    = W'($urandom);
      tick();
      check("bp_prod_valid", prod_valid, 1);
      check("bp_prod", prod, exp);
      check("bp_pp_ready", pp_ready, 0);
      check("bp_row_idx", row_idx, R - 1);
    end
    prod_ready = 1'b1;
    tick();
    prod_ready = 1'b0;
    pp_valid   = 1'b0;
    check("prod_valid_drop", prod_valid, 0);
    check("row_idx_rewind", row_idx, 0);
    check("pp_ready_idle", pp_ready, 1);
  endtask

  task automatic check_in_reset();
    check("rst_pp_ready", pp_ready, 0);
    check("rst_prod_valid", prod_valid, 0);
    check("rst_row_idx", row_idx, 0);
    check("rst_prod", prod, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{a: 16'hF003, b: 16'hFFFF, exp_exact: 64'hF002_0FFD, exp_trunc: 64'hF002_0E00, hold: 0};
    vecs[1] = '{a: 16'h0001, b: 16'h8000, exp_exact: 64'h0000_8000, exp_trunc: 64'h0000_8000, hold: 0};
    vecs[2] = '{a: 16'h0003, b: 16'h0005, exp_exact: 64'h0000_000F, exp_trunc: 64'h0000_0000, hold: 5};
    vecs[3] = '{a: 16'hFFFF, b: 16'hFFFF, exp_exact: 64'hFFFE_0001, exp_trunc: 64'hFFFD_F900, hold: 0};
    vecs[4] = '{a: 16'h0000, b: 16'h1234, exp_exact: 64'h0000_0000, exp_trunc: 64'h0000_0000, hold: 1};
    vecs[5] = '{a: 16'h1234, b: 16'h0001, exp_exact: 64'h0000_1234, exp_trunc: 64'h0000_1200, hold: 2};

    rst        = 1'b1;
    pp_valid   = 1'b0;
    pp_in      = '0;
    prod_ready = 1'b0;
    tick();
    tick();
    check_in_reset();
    rst = 1'b0;
    tick();
    check("idle_pp_ready", pp_ready, 1);
    check("idle_row_idx", row_idx, 0);

    // Table-driven products: rows are a wherever b has a 1.
    for (int i = 0; i < 6; i++) begin
      longint unsigned exp;
`ifdef APPROX_TRUNC_EN
      exp = vecs[i].exp_trunc;
`else
      exp = vecs[i].exp_exact;
`endif
      for (int k = 0; k < R; k++) rows[k] = vecs[i].b[k] ? vecs[i].a : 16'h0000;
      send_rows(R, 0);
      finish_product(exp, vecs[i].hold, 1'b1);
    end

    // Gapped input: pp_valid toggles every other cycle.
    for (int k = 0; k < R; k++) rows[k] = 16'hFFFF;
    send_rows(R, 1);
    finish_product(EXP_FFFF, 0, 1'b0);

    // Reset after 7 rows discards the partial sum.
    send_rows(7, 0);
    check("pre_rst_row_idx", row_idx, 7);
    rst      = 1'b1;
    pp_valid = 1'b1;
    tick();
    check_in_reset();
    tick();
    check_in_reset();
    pp_valid = 1'b0;
    rst      = 1'b0;
    tick();
    send_rows(R, 0);
    finish_product(EXP_FFFF, 0, 1'b0);

    // Reset while DONE holds a valid product: no pulse afterwards.
    send_rows(R, 0);
    check("done_before_rst", prod_valid, 1);
    rst = 1'b1;
    tick();
    check_in_reset();
    rst = 1'b0;
    tick();
    check("no_pulse_after_rst", prod_valid, 0);
    check("row0_after_rst", row_idx, 0);

    // Random products with random gaps and backpressure.
    for (int t = 0; t < 20; t++) begin
      for (int k = 0; k < R; k++) rows[k] = W'($urandom);
      if (t % 5 == 0) rows[$urandom_range(0, R - 1)] = 16'hFFFF;
      send_rows(R, 2);
      finish_product(model(), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pp_accumulator.md
Name: pp_accumulator

Overview:
- Consumer end of the partial-product path in the approximate multiplier datapath.
- Accepts one WIDTH-bit partial product per row, in row order 0..ROWS-1, from the clocked 16x1 partial-product generators.
- Shift-adds each row into a WIDTH+ROWS-bit accumulator and presents the full unsigned product with a valid/ready handshake.
- Sits between the partial-product generator array and the DNN MAC/activation stage.

Parameters:
- WIDTH, 16, partial-product width (multiplicand width).
- ROWS, 16, rows per product (multiplier width); row k is weighted by 2^k.
- TRUNC_BITS, 8, low product bits discarded when the approximate mode is compiled in; legal range 0..WIDTH+ROWS-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- pp_in  input  WIDTH  partial product for the current row.
- pp_valid  input  1  pp_in is valid this cycle.
- pp_ready  output  1  block accepts pp_in this cycle.
- row_idx  output  $clog2(ROWS)  index of the next row to be accepted.
- prod  output  WIDTH+ROWS  accumulated unsigned product.
- prod_valid  output  1  prod holds a completed product.
- prod_ready  input  1  downstream accepts prod.

Behaviour:
- Reset values: pp_ready=0, row_idx=0, prod=0, prod_valid=0. The FSM enters IDLE and the accumulator and row counter clear.
- States:
  - IDLE: pp_ready=1, acc=0, cnt=0. On a pp_valid&&pp_ready transfer, the FSM adds row 0 and goes to ACCUM.
  - ACCUM: pp_ready=1. Each transfer does acc += (pp_in << cnt) and cnt++. The transfer with cnt==ROWS-1 goes to DONE.
  - DONE: pp_ready=0, prod_valid=1, prod=acc (registered, stable). On prod_ready the FSM goes to IDLE, acc and cnt clear, and prod_valid drops the next cycle.
- A cycle with pp_valid=0 in IDLE/ACCUM holds all state. Gaps between rows are legal.
- Latency: prod_valid rises the cycle after the row ROWS-1 transfer. Minimum throughput is one product per ROWS+1 cycles (ROWS rows plus one DONE handshake cycle).
- The FSM never accepts a row in DONE. Rows for the next product wait until the IDLE cycle after prod_ready.
- Width: acc is WIDTH+ROWS bits and the maximum sum is (2^WIDTH-1)(2^ROWS-1), so overflow is impossible and no saturation logic exists.
- row_idx = cnt. It wraps to 0 only via DONE->IDLE and never exceeds ROWS-1.
- Reset mid-operation, in any state including DONE with prod_valid high: the partial sum is discarded with no output pulse. The next row accepted is row 0.
- pp_in is sampled only on a transfer. X on pp_in while pp_valid=0 must not propagate.

Optional Feature:
- Macro: APPROX_TRUNC_EN.
- Defined: the shifted row is masked with bits [TRUNC_BITS-1:0] forced to 0 before each add. prod[TRUNC_BITS-1:0] is always 0, and the adder below TRUNC_BITS is not synthesised. This is the lower-part truncation approximation.
- Undefined: exact accumulation; the TRUNC_BITS parameter is ignored.

Decomposition:
- Shared package mult_pkg holds:
  - WIDTH/ROWS defaults.
  - PROD_W = WIDTH+ROWS.
  - Typedef pp_t (WIDTH bits).
  - Typedef prod_t (PROD_W bits).
  - FSM enum acc_state_t {IDLE, ACCUM, DONE}.
- One combinational sub-module, pp_shift_mask: inputs pp_in and cnt, output the PROD_W-bit shifted row, with the APPROX_TRUNC_EN mask applied inside it. The FSM, counter and accumulator stay in pp_accumulator.

Test Plan:
- Exact corner: 16 rows of 0xF003 (a=0xF003, b=0xFFFF), pp_valid held 1 -> prod=0xF002_0FFD; prod_valid rises exactly 1 cycle after the 16th transfer.
- Single set row: rows 0..14 = 0x0000, row 15 = 0x0001 -> prod=0x0000_8000. Then rows for a=0x0003, b=0x0005 (rows 0 and 2 = 0x0003, others 0) -> prod=0x0000_000F.
- Backpressure: prod_ready held 0 for 5 cycles after DONE while pp_valid=1 -> prod and prod_valid stable, pp_ready=0, no row consumed. After prod_ready=1, the next product starts at row_idx=0.
- Gapped input: 0xFFFF rows with pp_valid toggling every other cycle -> prod=0xFFFE_0001, row_idx increments only on transfers.
- Reset mid-operation: assert rst after 7 rows -> prod_valid stays 0, row_idx=0, pp_ready=0 during rst. A fresh 16 rows of 0xFFFF -> prod=0xFFFE_0001.
- With APPROX_TRUNC_EN, TRUNC_BITS=8: 16 rows of 0xFFFF -> prod=0xFFFD_F900 with low byte 0. Without the macro, the same stimulus -> prod=0xFFFE_0001.
